// File: rtl/crack_pkg.sv
// Shared types and constants for the key-search scheduler.
package crack_pkg;

  localparam int unsigned NENG = 2;

  typedef logic [23:0] key_t;

  localparam key_t KEYMAX = 24'hFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/crack_sched_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves past the winner whenever a grant is issued.
module rr_arb
  import crack_pkg::*;
#(
  parameter int unsigned N = NENG
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] win;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    win   = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        win      = idx;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/crack_sched.sv
// Key-search scheduler: hands sequential candidate keys to the crack engines and
// shares the ciphertext port among them. CRACK_SCHED_STATS_EN adds an attempts counter.
module crack_sched #(
  parameter crack_pkg::key_t KEYMAX = crack_pkg::KEYMAX
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  output logic                                rdy,
  output logic [23:0]                         key,
  output logic                                key_valid,
  output logic [7:0]                          ct_addr,
  input  logic [7:0]                          ct_rddata,
  output logic [crack_pkg::NENG-1:0]          eng_start,
  output logic [crack_pkg::NENG-1:0][23:0]    eng_key,
  input  logic [crack_pkg::NENG-1:0]          eng_rdy,
  input  logic [crack_pkg::NENG-1:0]          eng_done,
  input  logic [crack_pkg::NENG-1:0]          eng_hit,
  input  logic [crack_pkg::NENG-1:0]          eng_ct_req,
  input  logic [crack_pkg::NENG-1:0][7:0]     eng_ct_addr,
  output logic [crack_pkg::NENG-1:0]          eng_ct_gnt,
  output logic [7:0]                          eng_ct_rddata,
  output logic [crack_pkg::NENG-1:0]          eng_ct_valid
`ifdef CRACK_SCHED_STATS_EN
  ,
  output logic [24:0]                         attempts
`endif
);
  import crack_pkg::*;

  sched_state_t    state, state_nx;
  key_t            counter, best, hit_min;
  logic            found, hit_any, dispatch, last_key;
  logic [NENG-1:0] outstanding, done_v, hit_v, disp_req, disp_gnt, ct_req;
  logic [7:0]      ct_addr_q;

  // Done/hit pulses only count for engines that actually hold an attempt.
  assign done_v        = eng_done & outstanding;
  assign hit_v         = done_v & eng_hit;
  assign hit_any       = |hit_v;
  assign disp_req      = (state == RUN && !hit_any) ? (eng_rdy & ~outstanding) : '0;
  assign dispatch      = |disp_gnt;
  assign last_key      = (counter == KEYMAX);
  assign rdy           = (state == IDLE);
  assign ct_req        = rst ? '0 : eng_ct_req;
  assign eng_ct_rddata = ct_rddata;

  rr_arb #(.N(NENG)) u_disp_arb (
    .clk (clk),
    .rst (rst),
    .req (disp_req),
    .gnt (disp_gnt)
  );

  rr_arb #(.N(NENG)) u_ct_arb (
    .clk (clk),
    .rst (rst),
    .req (ct_req),
    .gnt (eng_ct_gnt)
  );

  always_comb begin
    hit_min = '1;
    for (int unsigned e = 0; e < NENG; e++) begin
      if (hit_v[e] && eng_key[e] < hit_min) hit_min = eng_key[e];
    end
  end

  always_comb begin
    ct_addr = ct_addr_q;
    for (int unsigned e = 0; e < NENG; e++) begin
      if (eng_ct_gnt[e]) ct_addr = eng_ct_addr[e];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = RUN;
      RUN:     if (hit_any || (dispatch && last_key)) state_nx = DRAIN;
      DRAIN:   if ((outstanding & ~done_v) == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      best         <= '0;
      found        <= 1'b0;
      key          <= '0;
      key_valid    <= 1'b0;
      outstanding  <= '0;
      eng_start    <= '0;
      eng_key      <= '0;
      eng_ct_valid <= '0;
      ct_addr_q    <= '0;
    end else begin
      state        <= state_nx;
      eng_start    <= disp_gnt;
      eng_ct_valid <= eng_ct_gnt;
      outstanding  <= (outstanding & ~done_v) | disp_gnt;
      if (|eng_ct_gnt) ct_addr_q <= ct_addr;
      for (int unsigned e = 0; e < NENG; e++) begin
        if (disp_gnt[e]) eng_key[e] <= counter;
      end
      if (dispatch && !last_key) counter <= counter + 1'b1;
      case (state)
        IDLE: begin
          if (en) begin
            counter   <= '0;
            best      <= '0;
            found     <= 1'b0;
            key_valid <= 1'b0;
          end
        end
        RUN, DRAIN: begin
          if (hit_any && (!found || hit_min < best)) begin
            best  <= hit_min;
            found <= 1'b1;
          end
        end
        DONE: begin
          key_valid <= found;
          if (found) key <= best;
        end
        default: ;
      endcase
    end
  end

`ifdef CRACK_SCHED_STATS_EN
  logic [25:0] att_sum;

  always_comb begin
    att_sum = {1'b0, attempts};
    for (int unsigned e = 0; e < NENG; e++) begin
      att_sum = att_sum + 26'(done_v[e]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      attempts <= '0;
    end else if (rdy && en) begin
      attempts <= '0;
    end else begin
      attempts <= att_sum[25] ? '1 : att_sum[24:0];
    end
  end
`endif

endmodule

// File: tb/tb_crack_sched.sv
// Directed bench for crack_sched: two instances (full key range and KEYMAX=15)
// driven by a small fixed-latency engine model, plus a manually driven phase.
module tb_crack_sched;
  import crack_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rst = 1'b1;
  logic manual = 1'b0;
  logic en0 = 1'b0;
  logic en1 = 1'b0;

  logic        rdy0, rdy1, kv0, kv1;
  logic [23:0] key0, key1;
  logic [7:0]  ct_addr0, ct_addr1, ct_rdd0, ct_rdd1;
  logic [7:0]  ct_rd0 = '0;
  logic [7:0]  ct_rd1 = '0;

  logic [1:0]       start_o [2];
  logic [1:0][23:0] key_o   [2];
  logic [1:0]       busy    [2] = '{2'b00, 2'b00};
  logic [2:0]       cnt     [2][2];
  logic [23:0]      kk      [2][2];
  logic [1:0]       done_m  [2] = '{2'b00, 2'b00};
  logic [1:0]       hit_m   [2] = '{2'b00, 2'b00};
  logic [23:0]      hit_key [2] = '{24'h000018, 24'hFFFFFF};

  logic [1:0]      m_done = '0;
  logic [1:0]      m_hit  = '0;
  logic [1:0]      eng_rdy0, eng_done0, eng_hit0, eng_rdy1;
  logic [1:0]      ct_req0 = '0;
  logic [1:0]      gnt0, gnt1, ctv0, ctv1;
  logic [1:0][7:0] ct_areq0 = {8'hB1, 8'hA0};
  logic [1:0][7:0] ct_areq1 = '0;
  logic [1:0]      ct_req1 = '0;

  int starts1 = 0;
  int seen1 [16] = '{default: 0};

`ifdef CRACK_SCHED_STATS_EN
  logic [24:0] att0, att1;
`endif

  assign eng_rdy0  = manual ? 2'b11  : ~busy[0];
  assign eng_done0 = manual ? m_done : done_m[0];
  assign eng_hit0  = manual ? m_hit  : hit_m[0];
  assign eng_rdy1  = ~busy[1];

  crack_sched u_dut0 (
    .clk(clk), .rst(rst), .en(en0), .rdy(rdy0), .key(key0), .key_valid(kv0),
    .ct_addr(ct_addr0), .ct_rddata(ct_rd0), .eng_start(start_o[0]), .eng_key(key_o[0]),
    .eng_rdy(eng_rdy0), .eng_done(eng_done0), .eng_hit(eng_hit0), .eng_ct_req(ct_req0),
    .eng_ct_addr(ct_areq0), .eng_ct_gnt(gnt0), .eng_ct_rddata(ct_rdd0), .eng_ct_valid(ctv0)
`ifdef CRACK_SCHED_STATS_EN
    , .attempts(att0)
`endif
  );

  crack_sched #(.KEYMAX(24'h00000F)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .rdy(rdy1), .key(key1), .key_valid(kv1),
    .ct_addr(ct_addr1), .ct_rddata(ct_rd1), .eng_start(start_o[1]), .eng_key(key_o[1]),
    .eng_rdy(eng_rdy1), .eng_done(done_m[1]), .eng_hit(hit_m[1]), .eng_ct_req(ct_req1),
    .eng_ct_addr(ct_areq1), .eng_ct_gnt(gnt1), .eng_ct_rddata(ct_rdd1), .eng_ct_valid(ctv1)
`ifdef CRACK_SCHED_STATS_EN
    , .attempts(att1)
`endif
  );

  // Engine e takes 2+2*e cycles per attempt and hits only on hit_key.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      done_m[d] <= '0;
      hit_m[d]  <= '0;
      for (int e = 0; e < 2; e++) begin
        if (start_o[d][e] === 1'b1) begin
          busy[d][e] <= 1'b1;
          cnt[d][e]  <= 3'(2 + 2 * e);
          kk[d][e]   <= key_o[d][e];
        end else if (busy[d][e]) begin
          if (cnt[d][e] == 3'd0) begin
            busy[d][e]   <= 1'b0;
            done_m[d][e] <= 1'b1;
            hit_m[d][e]  <= (kk[d][e] == hit_key[d]);
          end else begin
            cnt[d][e] <= cnt[d][e] - 3'd1;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    ct_rd0 <= ct_addr0 ^ 8'h5A;
    ct_rd1 <= ct_addr1;
  end

  always @(posedge clk) begin
    for (int e = 0; e < 2; e++) begin
      if (start_o[1][e] === 1'b1) begin
        starts1++;
        if (key_o[1][e] < 24'd16) seen1[key_o[1][e][3:0]]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input int d, input int maxc, input string tag);
    int n;
    n = 0;
    while (((d == 0) ? rdy0 : rdy1) !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
    checks++;
    assert (((d == 0) ? rdy0 : rdy1) === 1'b1) else begin
      errors++;
      $error("FAIL %s: rdy still low after %0d cycles, expected 1", tag, n);
    end
  endtask

  task automatic pulse_en0();
    en0 = 1'b1;
    step();
    en0 = 1'b0;
  endtask

  task automatic done_pulse(input logic [1:0] d, input logic [1:0] h);
    m_done = d;
    m_hit  = h;
    step();
    m_done = '0;
    m_hit  = '0;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    logic [23:0] sel;

    rst = 1'b1;
    step();
    step();
    check("rst_rdy", rdy0, 1);
    check("rst_key", key0, 0);
    check("rst_key_valid", kv0, 0);
    check("rst_eng_start", start_o[0], 0);
    check("rst_eng_key", key_o[0], 0);
    check("rst_ct_gnt", gnt0, 0);
    check("rst_ct_valid", ctv0, 0);
    check("rst_ct_addr", ct_addr0, 0);
    rst = 1'b0;
    step();

    // ct port: both engines requesting continuously
    ct_req0 = 2'b11;
    #1;
    check("ct_gnt_a", gnt0, 2'b01);
    check("ct_addr_a", ct_addr0, 8'hA0);
    step();
    check("ct_valid_a", ctv0, 2'b01);
    check("ct_data_a", ct_rdd0, 8'hFA);
    check("ct_gnt_b", gnt0, 2'b10);
    check("ct_addr_b", ct_addr0, 8'hB1);
    step();
    check("ct_valid_b", ctv0, 2'b10);
    check("ct_data_b", ct_rdd0, 8'hEB);
    check("ct_gnt_c", gnt0, 2'b01);
    check("ct_addr_c", ct_addr0, 8'hA0);
    step();
    check("ct_valid_c", ctv0, 2'b01);
    check("ct_data_c", ct_rdd0, 8'hFA);
    ct_req0 = '0;
    #1;
    check("ct_idle_gnt", gnt0, 2'b00);
    check("ct_hold_addr", ct_addr0, 8'hA0);
    step();
    check("ct_valid_off", ctv0, 2'b00);

    // exhaustive run with KEYMAX=15 and no hits
    en1 = 1'b1;
    step();
    en1 = 1'b0;
    check("exh_busy", rdy1, 0);
    wait_rdy(1, 300, "exh_timeout");
    check("exh_starts", starts1, 16);
    bad = 0;
    for (int k = 0; k < 16; k++) if (seen1[k] != 1) bad++;
    check("exh_keys_once", bad, 0);
    check("exh_key_valid", kv1, 0);
    check("exh_rdy", rdy1, 1);
    repeat (10) step();
    check("exh_no_more_starts", starts1, 16);

    // single hit at key 0x18
    pulse_en0();
    check("hit_busy", rdy0, 0);
    wait_rdy(0, 400, "hit_timeout");
    check("hit_key", key0, 24'h000018);
    check("hit_key_valid", kv0, 1);
    repeat (3) step();
    check("hold_key_valid", kv0, 1);
    check("hold_key", key0, 24'h000018);

    // en during RUN is ignored
    pulse_en0();
    check("accept_clears_kv", kv0, 0);
    repeat (8) step();
    en0 = 1'b1;
    repeat (3) step();
    en0 = 1'b0;
    check("run_ignores_en", rdy0, 0);
    wait_rdy(0, 400, "reen_timeout");
    check("reen_key", key0, 24'h000018);
    check("reen_key_valid", kv0, 1);

    // reset in the middle of a search
    pulse_en0();
    repeat (6) step();
    check("midrun_busy", rdy0, 0);
    rst = 1'b1;
    step();
    check("mrst_rdy", rdy0, 1);
    check("mrst_key", key0, 0);
    check("mrst_key_valid", kv0, 0);
    check("mrst_eng_start", start_o[0], 0);
    check("mrst_eng_key", key_o[0], 0);
    check("mrst_ct_gnt", gnt0, 0);
    check("mrst_ct_valid", ctv0, 0);
    check("mrst_ct_addr", ct_addr0, 0);
    rst = 1'b0;
    pulse_en0();
    n = 0;
    while (start_o[0] === 2'b00 && n < 20) begin
      step();
      n++;
    end
    check("restart_seen", (start_o[0] !== 2'b00), 1);
    sel = (start_o[0][0] === 1'b1) ? key_o[0][0] : key_o[0][1];
    check("restart_first_key", sel, 0);
    wait_rdy(0, 400, "restart_timeout");
    check("restart_key", key0, 24'h000018);
    check("restart_key_valid", kv0, 1);

    // manual engines: simultaneous hits on keys 5 (eng0) and 4 (eng1)
    manual = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    pulse_en0();
    repeat (3) step();
    check("man_disp_01", key_o[0], {24'd1, 24'd0});
    done_pulse(2'b01, 2'b00);
    check("man_e0_k2", key_o[0][0], 24'd2);
    done_pulse(2'b10, 2'b00);
    check("man_e1_k3", key_o[0][1], 24'd3);
    done_pulse(2'b10, 2'b00);
    check("man_e1_k4", key_o[0][1], 24'd4);
    done_pulse(2'b01, 2'b00);
    check("man_e0_k5", key_o[0][0], 24'd5);
    done_pulse(2'b11, 2'b11);
    wait_rdy(0, 20, "man_timeout");
    check("man_lower_key", key0, 24'd4);
    check("man_key_valid", kv0, 1);
    done_pulse(2'b11, 2'b11);
    check("stray_done_rdy", rdy0, 1);
    check("stray_done_key", key0, 24'd4);
    manual = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
